// File: rtl/rv_pkg.sv
// Shared RV32I constants and writeback FSM state type.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension; flags illegal widths and misalignment.
module load_extend
  import rv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        fault_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o  = '0;
    fault_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {24'b0, byte_sel};
      F3_LH: begin
        data_o  = {{16{half_sel[15]}}, half_sel};
        fault_o = offset_i[0];
      end
      F3_LHU: begin
        data_o  = {16'b0, half_sel};
        fault_o = offset_i[0];
      end
      F3_LW: begin
        data_o  = word_i;
        fault_o = (offset_i != 2'b00);
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Retire-stage writeback: registers ALU/LUI/link results and waits on memory for loads.
module writeback_unit
  import rv_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       imm32_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              regWrite_o,
  output logic [4:0]        wrd_o,
  output logic [31:0]       wdata_o,
  output logic              err_o,
  output logic [31:0]       retire_cnt_o
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOAD_TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wrd_q, wrd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] retire_q, retire_d;

  logic        accept, is_load, timeout_hit;
  logic        op_writes;
  logic [31:0] op_wdata;
  logic [2:0]  le_f3;
  logic [1:0]  le_off;
  logic [31:0] le_data;
  logic        le_fault;

  assign in_ready_o  = (state_q == IDLE);
  assign accept      = in_valid_i && in_ready_o;
  assign is_load     = (opcode_i == OP_LOAD);
  assign timeout_hit = (timer_q == TIMER_LAST);

  // One extractor: in IDLE it vets the incoming load, in LOAD_WAIT it shapes the returned word.
  assign le_f3  = (state_q == LOAD_WAIT) ? ld_f3_q  : funct3_i;
  assign le_off = (state_q == LOAD_WAIT) ? ld_off_q : alu_result_i[1:0];

  load_extend u_load_extend (
    .funct3_i (le_f3),
    .offset_i (le_off),
    .word_i   (mem_rdata_i),
    .data_o   (le_data),
    .fault_o  (le_fault)
  );

  always_comb begin
    op_writes = 1'b1;
    op_wdata  = alu_result_i;
    case (opcode_i)
      OP_R, OP_I:          op_wdata = alu_result_i;
      OP_LUI:              op_wdata = imm32_i;
      OP_JAL, OP_JALR:     op_wdata = 32'(pc_i) + 32'd4;
      OP_STORE, OP_BRANCH: op_writes = 1'b0;
      default:             op_writes = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_load && !le_fault) state_d = LOAD_WAIT;
      LOAD_WAIT: if (mem_rvalid_i || timeout_hit)    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    err_d      = 1'b0;
    wrd_d      = wrd_q;
    wdata_d    = wdata_q;
    retire_d   = retire_q;
    timer_d    = timer_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            if (le_fault) begin
              err_d = 1'b1;
            end else begin
              ld_rd_d  = rd_i;
              ld_f3_d  = funct3_i;
              ld_off_d = alu_result_i[1:0];
              timer_d  = '0;
            end
          end else begin
            retire_d = retire_q + 32'd1;
            if (op_writes && (rd_i != 5'd0)) begin
              regwrite_d = 1'b1;
              wrd_d      = rd_i;
              wdata_d    = op_wdata;
            end
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid_i) begin
          retire_d = retire_q + 32'd1;
          if (ld_rd_q != 5'd0) begin
            regwrite_d = 1'b1;
            wrd_d      = ld_rd_q;
            wdata_d    = le_data;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q    <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      regwrite_q <= 1'b0;
      wrd_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      retire_q   <= '0;
    end else begin
      timer_q    <= timer_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      regwrite_q <= regwrite_d;
      wrd_q      <= wrd_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      retire_q   <= retire_d;
    end
  end

  assign regWrite_o   = regwrite_q;
  assign wrd_o        = wrd_q;
  assign wdata_o      = wdata_q;
  assign err_o        = err_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized checks of writeback_unit against a transaction-level model.
module tb_writeback_unit;

  localparam int AW = 14;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i, in_valid_i, mem_rvalid_i;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic [4:0]    rd_i;
  logic [31:0]   alu_result_i, imm32_i, mem_rdata_i;
  logic [AW-1:0] pc_i;
  logic          in_ready_o, regWrite_o, err_o;
  logic [4:0]    wrd_o;
  logic [31:0]   wdata_o, retire_cnt_o;

  writeback_unit #(.ADDR_W(AW), .LOAD_TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .rd_i         (rd_i),
    .alu_result_i (alu_result_i),
    .imm32_i      (imm32_i),
    .pc_i         (pc_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .regWrite_o   (regWrite_o),
    .wrd_o        (wrd_o),
    .wdata_o      (wdata_o),
    .err_o        (err_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit m_writes(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 ||
           op == 7'b1101111 || op == 7'b1100111;
  endfunction

  function automatic logic [31:0] m_result(input logic [6:0] op, input logic [31:0] alu,
                                           input logic [31:0] imm, input logic [AW-1:0] pc);
    if (op == 7'b0110111) return imm;
    if (op == 7'b1101111 || op == 7'b1100111) return 32'(pc) + 32'd4;
    return alu;
  endfunction

  function automatic bit m_load_bad(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && off[0]) return 1'b1;
    if (f3 == 3'd2 && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b - ((b & 32'h80) << 1);
      3'd4:    return b;
      3'd1:    return h - ((h & 32'h8000) << 1);
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  bit          started = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_wait  = 0;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic        e_rw = 1'b0, e_err = 1'b0;
  logic [4:0]  e_wrd = '0;
  logic [31:0] e_wdata = '0, e_cnt = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        m_busy = 1'b0; m_wait = 0;
        e_rw = 1'b0; e_err = 1'b0; e_wrd = '0; e_wdata = '0; e_cnt = '0;
      end else begin
        e_rw  = 1'b0;
        e_err = 1'b0;
        if (!m_busy) begin
          if (in_valid_i) begin
            if (opcode_i == 7'b0000011) begin
              if (m_load_bad(funct3_i, alu_result_i[1:0])) begin
                e_err = 1'b1;
                $display("txn t=%0t load fault f3=%0d off=%0d", $time, funct3_i, alu_result_i[1:0]);
              end else begin
                m_busy = 1'b1; m_wait = 0;
                m_rd = rd_i; m_f3 = funct3_i; m_off = alu_result_i[1:0];
              end
            end else begin
              e_cnt = e_cnt + 32'd1;
              if (m_writes(opcode_i) && rd_i != 5'd0) begin
                e_rw = 1'b1; e_wrd = rd_i;
                e_wdata = m_result(opcode_i, alu_result_i, imm32_i, pc_i);
              end
              $display("txn t=%0t op=%b rd=%0d write=%0d", $time, opcode_i, rd_i, e_rw);
            end
          end
        end else if (mem_rvalid_i) begin
          m_busy = 1'b0;
          e_cnt  = e_cnt + 32'd1;
          if (m_rd != 5'd0) begin
            e_rw = 1'b1; e_wrd = m_rd; e_wdata = m_load(m_f3, m_off, mem_rdata_i);
          end
          $display("txn t=%0t load commit rd=%0d data=%08h", $time, m_rd, m_load(m_f3, m_off, mem_rdata_i));
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_busy = 1'b0; e_err = 1'b1;
            $display("txn t=%0t load timeout rd=%0d", $time, m_rd);
          end
        end
      end
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready",    {31'b0, in_ready_o}, {31'b0, ~m_busy});
      chk("regWrite", {31'b0, regWrite_o}, {31'b0, e_rw});
      chk("err",      {31'b0, err_o},      {31'b0, e_err});
      chk("wrd",      {27'b0, wrd_o},      {27'b0, e_wrd});
      chk("wdata",    wdata_o,             e_wdata);
      chk("retire",   retire_cnt_o,        e_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] imm,
                       input logic [AW-1:0] pc);
    in_valid_i = v; opcode_i = op; funct3_i = f3; rd_i = rd;
    alu_result_i = alu; imm32_i = imm; pc_i = pc;
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111, 7'b1111111};

  initial begin
    rst_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_ready",  {31'b0, in_ready_o}, 32'd1);
    chk("rst_rw",     {31'b0, regWrite_o}, 32'd0);
    chk("rst_wrd",    {27'b0, wrd_o},      32'd0);
    chk("rst_wdata",  wdata_o,             32'd0);
    chk("rst_err",    {31'b0, err_o},      32'd0);
    chk("rst_cnt",    retire_cnt_o,        32'd0);

    // ADDI x3 = 5
    drive(1'b1, 7'b0010011, 3'd0, 5'd3, 32'd5, 32'd5, '0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    chk("addi_rw",    {31'b0, regWrite_o}, 32'd1);
    chk("addi_wrd",   {27'b0, wrd_o},      32'd3);
    chk("addi_wdata", wdata_o,             32'h0000_0005);
    tick();
    chk("addi_rw_off", {31'b0, regWrite_o}, 32'd0);
    chk("addi_cnt",    retire_cnt_o,        32'd1);

    // JAL rd=1 then rd=0
    drive(1'b1, 7'b1101111, 3'd0, 5'd1, 32'd0, 32'd0, 14'h0100);
    tick();
    drive(1'b1, 7'b1101111, 3'd0, 5'd0, 32'd0, 32'd0, 14'h0100);
    chk("jal_rw",    {31'b0, regWrite_o}, 32'd1);
    chk("jal_wdata", wdata_o,             32'h0000_0104);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    chk("jal0_rw",  {31'b0, regWrite_o}, 32'd0);
    chk("jal0_cnt", retire_cnt_o,        32'd3);

    // LB offset 2, data after 3 wait cycles
    drive(1'b1, 7'b0000011, 3'b000, 5'd5, 32'h0000_1002, 32'd0, '0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_ready_low", {31'b0, in_ready_o}, 32'd0);
      if (i == 2) begin mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0080_0000; end
      tick();
    end
    mem_rvalid_i = 1'b0;
    chk("lb_ready", {31'b0, in_ready_o}, 32'd1);
    chk("lb_rw",    {31'b0, regWrite_o}, 32'd1);
    chk("lb_wdata", wdata_o,             32'hFFFF_FF80);
    chk("lb_cnt",   retire_cnt_o,        32'd4);

    // LW misaligned -> fault
    drive(1'b1, 7'b0000011, 3'b010, 5'd7, 32'h0000_2002, 32'd0, '0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    chk("lwmis_err",   {31'b0, err_o},      32'd1);
    chk("lwmis_rw",    {31'b0, regWrite_o}, 32'd0);
    chk("lwmis_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    chk("lwmis_err_off", {31'b0, err_o}, 32'd0);

    // load with no rvalid -> timeout
    drive(1'b1, 7'b0000011, 3'b010, 5'd8, 32'h0000_3000, 32'd0, '0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    for (int i = 0; i < TO; i++) begin
      chk("to_ready_low", {31'b0, in_ready_o}, 32'd0);
      tick();
    end
    chk("to_err",   {31'b0, err_o},      32'd1);
    chk("to_ready", {31'b0, in_ready_o}, 32'd1);
    chk("to_rw",    {31'b0, regWrite_o}, 32'd0);
    chk("to_cnt",   retire_cnt_o,        32'd4);
    tick();

    // reset during LOAD_WAIT, late rvalid ignored
    drive(1'b1, 7'b0000011, 3'b010, 5'd9, 32'h0000_4000, 32'd0, '0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    chk("rstlw_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    mem_rvalid_i = 1'b0;
    chk("rstlw_rw",  {31'b0, regWrite_o}, 32'd0);
    chk("rstlw_err", {31'b0, err_o},      32'd0);
    chk("rstlw_cnt", retire_cnt_o,        32'd0);

    // four back-to-back ADDs
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'b0110011, 3'd0, 5'(10 + i), 32'(100 + i), 32'd0, '0);
      tick();
      chk("b2b_rw",    {31'b0, regWrite_o}, 32'd1);
      chk("b2b_wrd",   {27'b0, wrd_o},      32'(10 + i));
      chk("b2b_wdata", wdata_o,             32'(100 + i));
    end
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    chk("b2b_cnt", retire_cnt_o, 32'd4);
    tick();
    chk("b2b_rw_off", {31'b0, regWrite_o}, 32'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] alu;
      rst_i = ($urandom_range(99) == 0);
      alu = $urandom;
      if ($urandom_range(1) == 0) alu[1:0] = 2'b00;
      drive($urandom_range(1) == 1, ops[$urandom_range(9)], 3'($urandom_range(7)),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
            alu, $urandom, AW'($urandom));
      mem_rvalid_i = (c < 750) ? ($urandom_range(9) < 3) : ($urandom_range(19) == 0);
      mem_rdata_i  = $urandom;
      tick();
    end
    rst_i = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, '0);
    mem_rvalid_i = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
